dmem_lsu: RTL and testbench



---
 rtl/dmem_lsu_if.sv | 24 ++
 rtl/dmem_lsu.sv | 160 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface dmem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressed RV32I data memory with optional wait states and fault reporting.
// state   | meaning
// IDLE    | ready for a request; latches it on req_valid
// WAIT    | burning WAIT_CYCLES cycles of modelled memory latency
// EXEC    | access performed, response registered for the next cycle
module dmem_lsu #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32
) (
  input logic       clock,
  input logic       reset,
  dmem_lsu_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_TC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EXEC} state_t;

  state_t            state;
  state_t            state_next;
  logic              ready;
  logic [3:0]        wait_cnt;
  logic              lat_we;
  logic [2:0]        lat_f3;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [AW-1:0]     word_idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              bad_f3;
  logic              misalign;
  logic              fault;
  logic [31:0]       rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_data;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              do_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_EXEC;
      end
      ST_WAIT: if (wait_cnt == WAIT_TC) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign word_idx     = lat_addr[AW+1:2];
  assign lane         = lat_addr[1:0];
  // Every bit above the array is checked so no address aliases onto a real word.
  assign out_of_range = |lat_addr[ADDR_W-1:AW+2];
  assign bad_f3       = lat_we ? (lat_f3[2] || lat_f3 == 3'b011)
                               : (lat_f3 == 3'b011 || lat_f3[2:1] == 2'b11);
  assign misalign     = (lat_f3[1:0] == 2'b01 && lat_addr[0]) ||
                        (lat_f3[1:0] == 2'b10 && lat_addr[1:0] != 2'b00);
  assign fault        = out_of_range || bad_f3 || misalign;

  assign rd_word = mem[word_idx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'd0;
    case (lat_f3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = lat_wdata;
    case (lat_f3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{lat_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = lat_wdata;
      end
    endcase
  end

  assign do_write = (state == ST_EXEC) && lat_we && !fault;

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_f3    <= bus.req_funct3;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            if (state_next == ST_WAIT) wait_cnt <= 4'd1;
          end
        end
        ST_WAIT: wait_cnt <= (wait_cnt == WAIT_TC) ? 4'd0 : wait_cnt + 4'd1;
        ST_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_err   <= fault;
          rsp_rdata <= (fault || lat_we) ? 32'd0 : load_data;
        end
        default: wait_cnt <= 4'd0;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: one instance with no wait states, one with three, against a byte-array model.
module tb_dmem_lsu;
  localparam int DEPTH  = 128;
  localparam int NBYTES = DEPTH * 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_lsu_if #(.ADDR_W(32)) b0 ();
  dmem_lsu_if #(.ADDR_W(32)) b3 ();

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
    .clock(clock), .reset(reset), .bus(b0));
  dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .ADDR_W(32)) dut3 (
    .clock(clock), .reset(reset), .bus(b3));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_mem [2][NBYTES];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel != 0) ? b3.req_ready : b0.req_ready;
  endfunction
  function automatic logic get_valid(input int sel);
    return (sel != 0) ? b3.rsp_valid : b0.rsp_valid;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel != 0) ? b3.rsp_rdata : b0.rsp_rdata;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel != 0) ? b3.rsp_err : b0.rsp_err;
  endfunction

  task automatic drive_req(input int sel, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (sel != 0) begin
      b3.req_we = we; b3.req_funct3 = f3; b3.req_addr = addr; b3.req_wdata = wdata;
      b3.req_valid = 1'b1;
    end else begin
      b0.req_we = we; b0.req_funct3 = f3; b0.req_addr = addr; b0.req_wdata = wdata;
      b0.req_valid = 1'b1;
    end
  endtask

  task automatic drop_valid(input int sel);
    if (sel != 0) b3.req_valid = 1'b0;
    else          b0.req_valid = 1'b0;
  endtask

  // Reference: RV32I load/store semantics on a little-endian byte array.
  task automatic model(input int sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err);
    logic [7:0]  b;
    logic [15:0] h;
    logic [8:0]  a;
    int n;
    rd  = 32'd0;
    err = 1'b0;
    if (addr >= 32'(NBYTES)) err = 1'b1;
    if (we && f3 > 3'd2) err = 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) err = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2) != 0) err = 1'b1;
    if (f3 == 3'd2 && (addr % 4) != 0) err = 1'b1;
    if (err) return;
    a = addr[8:0];
    if (we) begin
      n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) ref_mem[sel][a + 9'(i)] = wdata[8*i +: 8];
    end else begin
      b = ref_mem[sel][a];
      case (f3)
        3'd0: rd = 32'($signed(b));
        3'd4: rd = {24'd0, b};
        3'd1: begin h = {ref_mem[sel][a + 9'd1], b}; rd = 32'($signed(h)); end
        3'd5: begin h = {ref_mem[sel][a + 9'd1], b}; rd = {16'd0, h}; end
        default: rd = {ref_mem[sel][a + 9'd3], ref_mem[sel][a + 9'd2],
                       ref_mem[sel][a + 9'd1], b};
      endcase
    end
  endtask

  task automatic wait_accept(input int sel, input string tag);
    int n = 0;
    while (!get_ready(sel) && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".accept"}, 32'(get_ready(sel)), 32'd1);
    tick();
    drop_valid(sel);
  endtask

  // Called right after the accepting edge; walks to the response and checks it.
  task automatic collect(input int sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag, output logic [31:0] got);
    int lat = 1;
    int w = (sel != 0) ? 3 : 0;
    logic [31:0] erd;
    logic eerr;
    model(sel, we, f3, addr, wdata, erd, eerr);
    while (!get_valid(sel) && lat < 40) begin
      chk({tag, ".busy"}, 32'(get_ready(sel)), 32'd0);
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(w + 2));
    chk({tag, ".err"}, 32'(get_err(sel)), 32'(eerr));
    chk({tag, ".rdata"}, get_rdata(sel), erd);
    chk({tag, ".ready"}, 32'(get_ready(sel)), 32'd1);
    got = get_rdata(sel);
    tick();
    chk({tag, ".pulse"}, 32'(get_valid(sel)), 32'd0);
  endtask

  task automatic access(input int sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag, output logic [31:0] got);
    drive_req(sel, we, f3, addr, wdata);
    wait_accept(sel, tag);
    collect(sel, we, f3, addr, wdata, tag, got);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic        we;
    b0.req_valid = 0; b0.req_we = 0; b0.req_funct3 = 0; b0.req_addr = 0; b0.req_wdata = 0;
    b3.req_valid = 0; b3.req_we = 0; b3.req_funct3 = 0; b3.req_addr = 0; b3.req_wdata = 0;
    #1;
    chk("rst.ready0", 32'(b0.req_ready), 32'd1);
    chk("rst.valid0", 32'(b0.rsp_valid), 32'd0);
    chk("rst.rdata0", b0.rsp_rdata, 32'd0);
    chk("rst.err0", 32'(b0.rsp_err), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < DEPTH; w++)
        access(s, 1'b1, 3'd2, 32'(w * 4), $urandom, "fill", got);

    access(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10", got);
    access(0, 1'b0, 3'd2, 32'h10, 0, "lw10", got);
    chk("lw10.const", got, 32'hDEADBEEF);
    access(0, 1'b0, 3'd0, 32'h10, 0, "lb10", got);
    chk("lb10.const", got, 32'hFFFFFFEF);
    access(0, 1'b0, 3'd4, 32'h13, 0, "lbu13", got);
    chk("lbu13.const", got, 32'h000000DE);
    access(0, 1'b0, 3'd1, 32'h12, 0, "lh12", got);
    chk("lh12.const", got, 32'hFFFFDEAD);
    access(0, 1'b0, 3'd5, 32'h10, 0, "lhu10", got);
    chk("lhu10.const", got, 32'h0000BEEF);
    access(0, 1'b1, 3'd0, 32'h11, 32'h55, "sb11", got);
    access(0, 1'b0, 3'd2, 32'h10, 0, "lw10b", got);
    chk("lw10b.const", got, 32'hDEAD55EF);
    access(0, 1'b1, 3'd1, 32'h12, 32'h1234, "sh12", got);
    access(0, 1'b0, 3'd2, 32'h10, 0, "lw10c", got);
    chk("lw10c.const", got, 32'h123455EF);

    access(0, 1'b0, 3'd2, 32'h11, 0, "lw11.fault", got);
    access(0, 1'b1, 3'd1, 32'h13, 32'hAAAA, "sh13.fault", got);
    access(0, 1'b0, 3'd2, 32'h10, 0, "lw10d", got);
    chk("lw10d.const", got, 32'h123455EF);
    access(0, 1'b1, 3'd2, 32'h1FC, 32'hA5A5_5A5A, "sw_last", got);
    access(0, 1'b1, 3'd2, 32'(NBYTES), 32'h0BAD_0BAD, "sw200.fault", got);
    access(0, 1'b0, 3'd2, 32'h1FC, 0, "lw_last", got);
    chk("lw_last.const", got, 32'hA5A5_5A5A);
    access(0, 1'b0, 3'd7, 32'h10, 0, "ld111.fault", got);
    access(0, 1'b1, 3'd2, 32'h8000_0010, 32'h0, "sw_alias.fault", got);
    access(0, 1'b0, 3'd2, 32'h10, 0, "lw10e", got);
    chk("lw10e.const", got, 32'h123455EF);

    // Second request held while the first is still in flight.
    drive_req(1, 1'b1, 3'd2, 32'h40, 32'h7777_8888);
    wait_accept(1, "ws.a");
    drive_req(1, 1'b0, 3'd2, 32'h40, 0);
    collect(1, 1'b1, 3'd2, 32'h40, 32'h7777_8888, "ws.a", got);
    drop_valid(1);
    collect(1, 1'b0, 3'd2, 32'h40, 0, "ws.b", got);
    chk("ws.b.const", got, 32'h7777_8888);

    for (int k = 0; k < 150; k++) begin
      for (int s = 0; s < 2; s++) begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
          0:       addr = $urandom;
          1:       addr = 32'(NBYTES - 4) + 32'($urandom_range(0, 7));
          default: addr = 32'($urandom_range(0, NBYTES - 1));
        endcase
        if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
        access(s, we, f3, addr, $urandom, "rand", got);
      end
    end

    access(1, 1'b1, 3'd2, 32'h20, 32'h1111_1111, "pre.sw20", got);
    access(1, 1'b0, 3'd2, 32'h20, 0, "pre.lw20", got);
    drive_req(1, 1'b1, 3'd2, 32'h20, 32'hCAFE_F00D);
    wait_accept(1, "abort");
    tick();
    reset = 1'b1;
    #1;
    chk("abort.valid", 32'(b3.rsp_valid), 32'd0);
    chk("abort.ready", 32'(b3.req_ready), 32'd1);
    chk("abort.rdata", b3.rsp_rdata, 32'd0);
    chk("abort.err", 32'(b3.rsp_err), 32'd0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort.novalid", 32'(b3.rsp_valid), 32'd0);
    end
    access(1, 1'b0, 3'd2, 32'h20, 0, "post.lw20", got);
    chk("post.lw20.const", got, 32'h1111_1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
